// File: rtl/iddmm_mul_pkg.sv
// Shared constants and types for the 128x128 IDDMM multiplier.
// Build option: IDDMM_MUL_LOW128_EN selects the low-128-bit product variant.
package iddmm_mul_pkg;

  localparam int LIMB_W    = 32;
  localparam int NUM_LIMBS = 4;
  localparam int OP_W      = 128;
  localparam int LATENCY   = 4;
  localparam int PP_W      = 2 * LIMB_W;

`ifdef IDDMM_MUL_LOW128_EN
  // Only the low half is needed, so every sum stays 128 bits wide.
  localparam bit LOW128 = 1'b1;
  localparam int RES_W  = OP_W;
  localparam int ROW_W  = OP_W;
`else
  // Row j spans limbs 0..3 of x shifted, so 128 + 32 bits hold it exactly.
  localparam bit LOW128 = 1'b0;
  localparam int RES_W  = 2 * OP_W;
  localparam int ROW_W  = OP_W + LIMB_W;
`endif

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [PP_W-1:0]   pprod_t;
  typedef logic [2*OP_W-1:0] product_t;

endpackage

// File: rtl/iddmm_mul_limb32.sv
// Registered 32x32 -> 64 unsigned limb multiplier (pipeline stage S2).
module iddmm_mul_limb32
  import iddmm_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  output pprod_t            p
);

  // Exact limb product; 64 bits cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= pprod_t'(a) * pprod_t'(b);
  end

endmodule

// File: rtl/iddmm_mul_128.sv
// Fully pipelined 128x128 unsigned multiplier, 4 register stages, 1 product/cycle.
// Build option: IDDMM_MUL_LOW128_EN returns only (x*y) mod 2^128 and omits the
// limb products with i+j >= 4.
module iddmm_mul_128
  import iddmm_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  y,
  output logic [RES_W-1:0] result
);

  logic [NUM_LIMBS-1:0][LIMB_W-1:0] x_q, y_q;
  pprod_t                           pp [NUM_LIMBS][NUM_LIMBS];
  logic [NUM_LIMBS-1:0][ROW_W-1:0]  row_d, row_q;
  logic [RES_W-1:0]                 res_d;

  // S1: capture operands; reset holds them at zero so nothing is taken in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x;
      y_q <= y;
    end
  end

  // S2: limb partial products; the low build skips the ones landing at or above bit 128.
  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_i
    for (genvar j = 0; j < NUM_LIMBS; j++) begin : g_j
      if (!LOW128 || (i + j) < NUM_LIMBS) begin : g_mul
        iddmm_mul_limb32 u_mul (
          .clk   (clk),
          .rst_n (rst_n),
          .a     (x_q[i]),
          .b     (y_q[j]),
          .p     (pp[i][j])
        );
      end else begin : g_none
        assign pp[i][j] = '0;
      end
    end
  end

  // S3 combinational: row j collects x_i*y_j aligned at 32*i.
  always_comb begin
    row_d = '0;
    for (int j = 0; j < NUM_LIMBS; j++)
      for (int i = 0; i < NUM_LIMBS; i++)
        row_d[j] = row_d[j] + (ROW_W'(pp[i][j]) << (LIMB_W * i));
  end

  // S3: register row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
  end

  // S4 combinational: rows aligned at 32*j; truncation to RES_W gives the low half.
  always_comb begin
    res_d = '0;
    for (int j = 0; j < NUM_LIMBS; j++)
      res_d = res_d + (RES_W'(row_q[j]) << (LIMB_W * j));
  end

  // S4: registered product output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result <= '0;
    else        result <= res_d;
  end

endmodule

// File: tb/tb_iddmm_mul_128.sv
// Self-checking bench for iddmm_mul_128 (both builds, via IDDMM_MUL_LOW128_EN).
module tb_iddmm_mul_128;

`ifdef IDDMM_MUL_LOW128_EN
  localparam int RW = 128;
  localparam logic [RW-1:0] MAX_EXP = 128'h1;
`else
  localparam int RW = 256;
  localparam logic [RW-1:0] MAX_EXP =
    {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h0000_0000_0000_0000_0000_0000_0000_0001};
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [127:0]   x = '0, y = '0;
  logic [RW-1:0]  result;

  int n_vec = 0;
  int n_bad = 0;

  iddmm_mul_128 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x),
    .y      (y),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]  x;
    logic [127:0]  y;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t tbl [4];

  // Reference: exact 256-bit product, truncated to the build's result width.
  function automatic logic [RW-1:0] model(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    p = {128'b0, a} * {128'b0, b};
    return p[RW-1:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] prev, e;
  logic [127:0]  a, b;

  initial begin
    tbl[0] = '{x: 128'd0, y: 128'd0, exp: '0};
    tbl[1] = '{x: 128'd3, y: 128'd5, exp: RW'(8'h0F)};
    tbl[2] = '{x: 128'hFFFF_FFFF, y: 128'hFFFF_FFFF, exp: RW'(64'hFFFF_FFFE_0000_0001)};
    tbl[3] = '{x: {128{1'b1}}, y: {128{1'b1}}, exp: MAX_EXP};

    // Reset held: output stays zero whatever the operands do.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      x = rnd128();
      y = rnd128();
      #1;
      check("reset_hold", result, '0);
    end
    @(negedge clk);
    x = '0; y = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_zero", result, '0);
    end

    // Directed table: previous value at edge 3, new value at edge 4, held through edge 10.
    prev = '0;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      x = tbl[v].x;
      y = tbl[v].y;
      tick(); tick(); tick();
      check($sformatf("tbl%0d_edge3", v), result, prev);
      tick();
      check($sformatf("tbl%0d_edge4", v), result, tbl[v].exp);
      for (int k = 0; k < 6; k++) tick();
      check($sformatf("tbl%0d_edge10", v), result, tbl[v].exp);
      prev = tbl[v].exp;
    end

    // Streaming: new pair every cycle; first half 32-bit, second half full width.
    for (int t = 0; t < 103; t++) begin
      @(negedge clk);
      if (t < 100) begin
        a = (t < 50) ? 128'($urandom) : rnd128();
        b = (t < 50) ? 128'($urandom) : rnd128();
        x = a; y = b;
        exp_q.push_back(model(a, b));
      end
      tick();
      if (t >= 3) begin
        e = exp_q.pop_front();
        check($sformatf("stream%0d", t - 3), result, e);
      end
    end

    // Held pairs: value constant from edge 4 onward.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      a = rnd128(); b = rnd128();
      x = a; y = b;
      for (int k = 0; k < 4; k++) tick();
      check($sformatf("hold%0d_edge4", v), result, model(a, b));
      for (int k = 0; k < 6; k++) tick();
      check($sformatf("hold%0d_edge10", v), result, model(a, b));
    end

    // Reset mid-flight: 7*9 must never surface.
    @(negedge clk);
    x = 128'd7; y = 128'd9;
    tick(); tick();
    @(negedge clk);
    x = 128'd11; y = 128'd13;
    rst_n = 1'b0;
    #1;
    check("midreset_async", result, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midreset_hold", result, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x = 128'd2; y = 128'd21;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("release_zero", result, '0);
    end
    tick();
    check("release_first", result, RW'(8'd42));
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      a = rnd128(); b = rnd128();
      x = a; y = b;
      for (int k = 0; k < 4; k++) tick();
      check($sformatf("release_rand%0d", v), result, model(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
